// File: rtl/mult_pkg.sv
// Shared encodings for the multiply/HI-LO control stage.
package mult_pkg;

  localparam int HILO_W = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_MTHI  = 2'b10,
    OP_MTLO  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_WRITE = 2'b11
  } state_e;

endpackage

// File: rtl/mult_sign_fix.sv
// Converts a signed 32x32 product into the unsigned product when the op was MULTU.
module mult_sign_fix
  import mult_pkg::*;
(
  input  logic [2*HILO_W-1:0] product,
  input  logic [HILO_W-1:0]   a,
  input  logic [HILO_W-1:0]   b,
  input  logic                is_unsigned,
  output logic [2*HILO_W-1:0] result
);

  logic [HILO_W-1:0] add_a;
  logic [HILO_W-1:0] add_b;
  logic [HILO_W-1:0] hi_fix;

  // A set sign bit on one operand means the signed product is short by the other operand << 32.
  assign add_a  = (is_unsigned && a[HILO_W-1]) ? b : '0;
  assign add_b  = (is_unsigned && b[HILO_W-1]) ? a : '0;
  assign hi_fix = product[2*HILO_W-1:HILO_W] + add_a + add_b;
  assign result = {hi_fix, product[HILO_W-1:0]};

endmodule

// File: rtl/mult_hilo_ctrl.sv
// Multiply/HI-LO control: issues requests to the 1-cycle signed multiplier and owns HI/LO.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | accepting MULT/MULTU/MTHI/MTLO
// ST_ISSUE | mult_begin high, operands presented
// ST_WAIT  | waiting for mult_end, then HI/LO written
// ST_WRITE | done pulse, back to idle
module mult_hilo_ctrl
  import mult_pkg::*;
#(
  parameter logic [31:0] HILO_RST = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [1:0]          in_op,
  input  logic [HILO_W-1:0]   in_a,
  input  logic [HILO_W-1:0]   in_b,
  output logic                busy,
  output logic                done,
  output logic                mult_begin,
  output logic [HILO_W-1:0]   mult_op1,
  output logic [HILO_W-1:0]   mult_op2,
  input  logic [2*HILO_W-1:0] product,
  input  logic                mult_end,
  output logic [HILO_W-1:0]   hi,
  output logic [HILO_W-1:0]   lo
);

  state_e              state;
  logic [HILO_W-1:0]   op_a;
  logic [HILO_W-1:0]   op_b;
  logic                op_unsigned;
  logic [2*HILO_W-1:0] fixed_product;

  mult_sign_fix u_sign_fix (
    .product     (product),
    .a           (op_a),
    .b           (op_b),
    .is_unsigned (op_unsigned),
    .result      (fixed_product)
  );

  assign busy     = (state != ST_IDLE);
  assign mult_op1 = op_a;
  assign mult_op2 = op_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      hi          <= HILO_RST;
      lo          <= HILO_RST;
      done        <= 1'b0;
      mult_begin  <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      op_unsigned <= 1'b0;
    end else begin
      done       <= 1'b0;
      mult_begin <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            case (in_op)
              OP_MTHI: hi <= in_a;
              OP_MTLO: lo <= in_a;
              default: begin
                op_a        <= in_a;
                op_b        <= in_b;
                op_unsigned <= (in_op == OP_MULTU);
                mult_begin  <= 1'b1;
                state       <= ST_ISSUE;
              end
            endcase
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          // mult_end outside WAIT may be stale from an aborted op, so only honour it here.
          if (mult_end) begin
            {hi, lo} <= fixed_product;
            done     <= 1'b1;
            state    <= ST_WRITE;
          end
        end
        ST_WRITE: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Directed bench for mult_hilo_ctrl with a behavioural 1-cycle signed multiplier.
module tb_mult_hilo_ctrl;
  import mult_pkg::*;

  localparam logic [31:0] RST_VAL = 32'hA5A5_5A5A;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        busy;
  logic        done;
  logic        mult_begin;
  logic [31:0] mult_op1;
  logic [31:0] mult_op2;
  logic [63:0] product;
  logic        mult_end;
  logic [31:0] hi;
  logic [31:0] lo;

  logic        model_en;
  logic        model_end;
  logic [63:0] model_prod;
  logic        force_end;
  logic [63:0] force_prod;

  int n_checks;
  int n_fail;
  int done_cnt;

  mult_hilo_ctrl #(.HILO_RST(RST_VAL)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .busy       (busy),
    .done       (done),
    .mult_begin (mult_begin),
    .mult_op1   (mult_op1),
    .mult_op2   (mult_op2),
    .product    (product),
    .mult_end   (mult_end),
    .hi         (hi),
    .lo         (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Signed multiplier: mult_end and product one cycle after the begin pulse, no reset.
  always @(posedge clk) begin
    model_end <= model_en & mult_begin;
    if (mult_begin)
      model_prod <= {{32{mult_op1[31]}}, mult_op1} * {{32{mult_op2[31]}}, mult_op2};
  end

  assign mult_end = model_end | force_end;
  assign product  = force_end ? force_prod : model_prod;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_mult(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check({tag, " begin@N+1"}, 64'(mult_begin), 64'd1);
    check({tag, " busy@N+1"}, 64'(busy), 64'd1);
    check({tag, " op1"}, 64'(mult_op1), 64'(a));
    check({tag, " op2"}, 64'(mult_op2), 64'(b));
    @(negedge clk);
    check({tag, " begin@N+2"}, 64'(mult_begin), 64'd0);
    check({tag, " done@N+2"}, 64'(done), 64'd0);
    @(negedge clk);
    check({tag, " done@N+3"}, 64'(done), 64'd1);
    check({tag, " hi"}, 64'(hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(lo), 64'(exp_lo));
    check({tag, " busy@N+3"}, 64'(busy), 64'd1);
    @(negedge clk);
    check({tag, " done@N+4"}, 64'(done), 64'd0);
    check({tag, " busy@N+4"}, 64'(busy), 64'd0);
  endtask

  task automatic move_to(input logic [1:0] op, input logic [31:0] data);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = data; in_b = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_before;
    n_checks = 0; n_fail = 0; done_cnt = 0;
    reset = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0;
    model_en = 1'b1; force_end = 1'b0; force_prod = '0;
    repeat (3) @(negedge clk);
    check("rst hi", 64'(hi), 64'(RST_VAL));
    check("rst lo", 64'(lo), 64'(RST_VAL));
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst begin", 64'(mult_begin), 64'd0);
    check("rst ops", {mult_op1, mult_op2}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_mult("mult -1*2",  OP_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_mult("multu max*2", OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE);
    run_mult("multu 8x8",   OP_MULTU, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_mult("mult 7f^2",   OP_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001);
    run_mult("mult -3*5",   OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_mult("multu 3*b",   OP_MULTU, 32'h0000_0003, 32'hFFFF_FFFB, 32'h0000_0002, 32'hFFFF_FFF1);

    // MTHI then MTLO back to back
    move_to(OP_MTHI, 32'h1234_5678);
    move_to(OP_MTLO, 32'h9ABC_DEF0);
    @(negedge clk);
    in_valid = 1'b0;
    check("mthi hi", 64'(hi), 64'h1234_5678);
    check("mtlo lo", 64'(lo), 64'h9ABC_DEF0);
    check("mtxx busy", 64'(busy), 64'd0);

    // Requests during ISSUE/WAIT are ignored
    done_before = done_cnt;
    @(negedge clk);
    in_valid = 1'b1; in_op = OP_MULT; in_a = 32'h0000_0010; in_b = 32'h0000_0010;
    @(posedge clk);
    #1 in_op = OP_MULTU; in_a = 32'hFFFF_FFFF; in_b = 32'hFFFF_FFFF;
    @(negedge clk);
    check("ign begin", 64'(mult_begin), 64'd1);
    @(posedge clk);
    #1 in_op = OP_MTHI; in_a = 32'hCAFE_F00D;
    @(negedge clk);
    check("ign op1 hold", 64'(mult_op1), 64'h10);
    check("ign op2 hold", 64'(mult_op2), 64'h10);
    check("ign hi untouched", 64'(hi), 64'h1234_5678);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("ign hi", 64'(hi), 64'h0);
    check("ign lo", 64'(lo), 64'h100);
    repeat (4) @(negedge clk);
    check("ign single done", 64'(done_cnt - done_before), 64'd1);
    check("ign hi final", 64'(hi), 64'h0);
    check("ign busy", 64'(busy), 64'd0);

    // Reset during WAIT, stale mult_end afterwards
    move_to(OP_MTHI, 32'h1111_1111);
    move_to(OP_MTLO, 32'h2222_2222);
    model_en = 1'b0;
    done_before = done_cnt;
    @(negedge clk);
    in_valid = 1'b1; in_op = OP_MULT; in_a = 32'h0000_0007; in_b = 32'h0000_0009;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rw busy in wait", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("rw abort hi", 64'(hi), 64'(RST_VAL));
    check("rw abort lo", 64'(lo), 64'(RST_VAL));
    check("rw abort busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0; force_end = 1'b1; force_prod = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    force_end = 1'b0;
    repeat (3) @(negedge clk);
    check("rw hi", 64'(hi), 64'(RST_VAL));
    check("rw lo", 64'(lo), 64'(RST_VAL));
    check("rw no done", 64'(done_cnt - done_before), 64'd0);
    check("rw busy", 64'(busy), 64'd0);

    // mult_end while idle
    move_to(OP_MTHI, 32'h3333_3333);
    @(negedge clk);
    in_valid = 1'b0;
    done_before = done_cnt;
    force_end = 1'b1; force_prod = 64'hDEAD_BEEF_FEED_FACE;
    repeat (3) @(negedge clk);
    force_end = 1'b0;
    @(negedge clk);
    check("idle end hi", 64'(hi), 64'h3333_3333);
    check("idle end lo", 64'(lo), 64'(RST_VAL));
    check("idle end done", 64'(done_cnt - done_before), 64'd0);
    model_en = 1'b1;

    run_mult("post mult", OP_MULT, 32'h0000_0100, 32'h0000_0100, 32'h0000_0000, 32'h0001_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_hilo_ctrl.md
Name: mult_hilo_ctrl

Overview:
Multiply/HI-LO control stage that sits between the EXE stage and the 1-cycle Booth/CSA signed multiplier. It registers MULT/MULTU requests and drives the multiplier's begin/operand handshake. On completion it applies the unsigned correction for MULTU and writes the HI/LO architectural registers. It also services MTHI/MTLO and raises busy so that MFHI/MFLO readers stall until HI/LO are final.

Parameters:
HILO_RST, 32'h0000_0000, reset value of both HI and LO

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  request present; sampled only when state is IDLE
in_op  input  2  00 MULT (signed), 01 MULTU, 10 MTHI, 11 MTLO
in_a  input  32  rs operand; also the MTHI/MTLO data
in_b  input  32  rt operand
busy  output  1  multiply in flight; EXE/ID must stall MFHI/MFLO and new mult ops
done  output  1  one-cycle pulse when HI/LO are updated by a multiply
mult_begin  output  1  start pulse to multiplier
mult_op1  output  32  multiplier operand 1 (registered a)
mult_op2  output  32  multiplier operand 2 (registered b)
product  input  64  multiplier result, valid while mult_end=1
mult_end  input  1  multiplier completion
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (async, active-high):
  - state=IDLE; hi=lo=HILO_RST; busy=0, done=0, mult_begin=0; op regs=0.
- States: IDLE, ISSUE, WAIT, WRITE. busy = (state != IDLE), decoded from registered state.
- IDLE:
  - in_valid with op MTHI: hi<=in_a at that clock edge; stay IDLE.
  - in_valid with op MTLO: lo<=in_a at that clock edge; stay IDLE.
  - in_valid with op MULT/MULTU: latch a, b and the unsigned flag; go to ISSUE.
- ISSUE: mult_begin=1 for exactly this one cycle; go to WAIT.
- WAIT:
  - mult_begin=0.
  - On mult_end=1: latch {hi,lo}<=corrected product; go to WRITE.
  - Otherwise hold WAIT. There is no timeout; the multiplier guarantees mult_end in the cycle after the begin pulse.
- WRITE: done=1 for one cycle; go to IDLE.
- Latency: accept at edge N; mult_begin high in cycle N+1; mult_end high in cycle N+2; hi/lo new from edge N+3, the same cycle done is high; busy low from cycle N+4.
- mult_op1/mult_op2 are driven from the latched regs and stay stable from ISSUE through WAIT.
- Arithmetic: the multiplier is signed-only.
  - MULT: {hi,lo} = product.
  - MULTU: {hi,lo} = product + (a[31] ? {b,32'b0} : 0) + (b[31] ? {a,32'b0} : 0), taken mod 2^64. Only the high word changes: hi = product[63:32] + (a[31]?b:0) + (b[31]?a:0), mod 2^32; lo = product[31:0].
- in_valid while busy: ignored, no latch. The requester holds the request under the stall.
- mult_end seen in IDLE, ISSUE or WRITE (e.g. left over from a multiply interrupted by reset): ignored.
- Reset mid-operation: abort to IDLE with HI/LO at HILO_RST. The multiplier itself has no reset, so its pending mult_end is discarded by the rule above.
- MTHI/MTLO issued while busy: ignored, like any request. HI/LO results are never partially written.

Decomposition:
- Shared package mult_pkg holds:
  - op encodings OP_MULT=2'b00, OP_MULTU=2'b01, OP_MTHI=2'b10, OP_MTLO=2'b11;
  - state encodings;
  - HILO width constant 32.
- One combinational sub-module, mult_sign_fix: inputs product, a, b, unsigned flag; output corrected 64-bit result. Verification can exercise it standalone.

Test Plan:
- MULT a=FFFFFFFF, b=00000002 (product FFFFFFFF_FFFFFFFE) -> hi=FFFFFFFF, lo=FFFFFFFE; done at N+3; busy low at N+4.
- MULTU a=FFFFFFFF, b=00000002 -> hi=00000001, lo=FFFFFFFE. Also a=b=80000000 -> hi=40000000, lo=00000000.
- MTHI 12345678 then MTLO 9ABCDEF0 in consecutive idle cycles -> hi=12345678, lo=9ABCDEF0; busy never asserts.
- MULT accepted, then a new MULTU and an MTHI presented during ISSUE/WAIT -> both ignored; single done; hi/lo reflect only the first op.
- Assert reset during WAIT, with mult_end high in the following cycle -> hi=lo=HILO_RST, state IDLE, no done pulse, no HI/LO write.
- mult_end forced high while IDLE -> no change to hi/lo, no done.
